// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle control FSM: opcodes, state
// encoding, mux select encodings and the bundled control word.
package multicycle_pkg;

   // ISA opcodes (IR[15:12])
   localparam logic [3:0] OP_R    = 4'b0000;
   localparam logic [3:0] OP_ADDI = 4'b0001;
   localparam logic [3:0] OP_ANDI = 4'b0010;
   localparam logic [3:0] OP_ORI  = 4'b0011;
   localparam logic [3:0] OP_SUBI = 4'b0100;
   localparam logic [3:0] OP_LHW  = 4'b0111;
   localparam logic [3:0] OP_SHW  = 4'b1000;
   localparam logic [3:0] OP_BEQ  = 4'b1001;
   localparam logic [3:0] OP_BNE  = 4'b1010;
   localparam logic [3:0] OP_BLT  = 4'b1011;
   localparam logic [3:0] OP_BGT  = 4'b1100;
   localparam logic [3:0] OP_JMP  = 4'b1111;

   // ALU operation codes used outside the opcode pass-through states
   localparam logic [3:0] ALUOP_RTYPE = 4'b0000;
   localparam logic [3:0] ALUOP_ADD   = 4'b0001;

   // ALU B operand select
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BOFF = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_EXEC_R    = 4'd2,
      ST_EXEC_I    = 4'd3,
      ST_ALU_WB    = 4'd4,
      ST_MEM_ADDR  = 4'd5,
      ST_MEM_READ  = 4'd6,
      ST_MEM_WB    = 4'd7,
      ST_MEM_WRITE = 4'd8,
      ST_BRANCH    = 4'd9,
      ST_JUMP      = 4'd10,
      ST_HALT      = 4'd11
   } state_t;

   // Complete set of datapath controls produced each cycle
   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       sign_ext;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_op;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       halted;
      logic       retire;
   } ctrl_t;

   // Opcode dispatch out of DECODE; anything unlisted is illegal and halts
   function automatic state_t decode_next(input logic [3:0] op);
      state_t nxt;
      case (op)
         OP_R:                             nxt = ST_EXEC_R;
         OP_ADDI, OP_ANDI, OP_ORI, OP_SUBI: nxt = ST_EXEC_I;
         OP_LHW, OP_SHW:                   nxt = ST_MEM_ADDR;
         OP_BEQ, OP_BNE, OP_BLT, OP_BGT:   nxt = ST_BRANCH;
         OP_JMP:                           nxt = ST_JUMP;
         default:                          nxt = ST_HALT;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational control-word generator: maps the current state, the
// captured opcode and the memory handshake onto the datapath controls.
module multicycle_ctrl_decode
   import multicycle_pkg::*;
(
   input  state_t     i_state,
   input  logic [3:0] i_op_q,
   input  logic       i_mem_ready,
   output ctrl_t      o_ctrl
);

   // Per-state control word; every field not set stays 0
   always_comb begin
      o_ctrl = '0;
      case (i_state)
         ST_FETCH: begin
            o_ctrl.mem_req   = 1'b1;
            o_ctrl.mem_read  = 1'b1;
            o_ctrl.alu_src_b = SRCB_ONE;
            o_ctrl.alu_op    = ALUOP_ADD;
            o_ctrl.pc_source = PCSRC_ALU;
            // IR and PC only load once the fetch data is actually there
            o_ctrl.ir_write  = i_mem_ready;
            o_ctrl.pc_write  = i_mem_ready;
         end
         ST_DECODE: begin
            o_ctrl.alu_src_b = SRCB_BOFF;
            o_ctrl.alu_op    = ALUOP_ADD;
            o_ctrl.sign_ext  = 1'b1;
         end
         ST_EXEC_R: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_REG;
            o_ctrl.alu_op    = ALUOP_RTYPE;
         end
         ST_EXEC_I: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = i_op_q;
            // logical immediates are zero-extended, arithmetic ones sign-extended
            o_ctrl.sign_ext  = (i_op_q == OP_ADDI) || (i_op_q == OP_SUBI);
         end
         ST_ALU_WB: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.reg_dst   = (i_op_q == OP_R);
            o_ctrl.retire    = 1'b1;
         end
         ST_MEM_ADDR: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.sign_ext  = 1'b1;
            o_ctrl.alu_op    = i_op_q;
         end
         ST_MEM_READ: begin
            o_ctrl.mem_req  = 1'b1;
            o_ctrl.mem_read = 1'b1;
            o_ctrl.iord     = 1'b1;
         end
         ST_MEM_WB: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
            o_ctrl.retire     = 1'b1;
         end
         ST_MEM_WRITE: begin
            o_ctrl.mem_req   = 1'b1;
            o_ctrl.mem_write = 1'b1;
            o_ctrl.iord      = 1'b1;
            o_ctrl.retire    = i_mem_ready;
         end
         ST_BRANCH: begin
            o_ctrl.alu_src_a     = 1'b1;
            o_ctrl.alu_src_b     = SRCB_REG;
            o_ctrl.alu_op        = i_op_q;
            o_ctrl.pc_write_cond = 1'b1;
            o_ctrl.pc_source     = PCSRC_ALUOUT;
            o_ctrl.retire        = 1'b1;
         end
         ST_JUMP: begin
            o_ctrl.pc_write  = 1'b1;
            o_ctrl.pc_source = PCSRC_JUMP;
            o_ctrl.retire    = 1'b1;
         end
         ST_HALT: begin
            o_ctrl.halted = 1'b1;
         end
         default: begin
            o_ctrl = '0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencing controller: state register, opcode capture,
// retired-instruction counter and reset gating of all outputs.
module multicycle_control_fsm
   import multicycle_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       op,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemToReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             SignExt,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [3:0]       ALUOp,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic [1:0]       PCSource,
   output logic             halted,
   output logic             instr_retired,
   output logic [CNT_W-1:0] retired_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic [3:0]       r_op_q;
   logic [CNT_W-1:0] r_count;
   ctrl_t            w_ctrl;
   ctrl_t            w_out;

   multicycle_ctrl_decode u_decode (
      .i_state     (r_state),
      .i_op_q      (r_op_q),
      .i_mem_ready (mem_ready),
      .o_ctrl      (w_ctrl)
   );

   // Reset forces every output low in the same cycle, even mid-access
   always_comb begin
      if (rst) begin
         w_out = '0;
      end else begin
         w_out = w_ctrl;
      end
   end

   assign mem_req       = w_out.mem_req;
   assign IorD          = w_out.iord;
   assign MemRead       = w_out.mem_read;
   assign MemWrite      = w_out.mem_write;
   assign IRWrite       = w_out.ir_write;
   assign MemToReg      = w_out.mem_to_reg;
   assign RegDst        = w_out.reg_dst;
   assign RegWrite      = w_out.reg_write;
   assign SignExt       = w_out.sign_ext;
   assign ALUSrcA       = w_out.alu_src_a;
   assign ALUSrcB       = w_out.alu_src_b;
   assign ALUOp         = w_out.alu_op;
   assign PCWrite       = w_out.pc_write;
   assign PCWriteCond   = w_out.pc_write_cond;
   assign PCSource      = w_out.pc_source;
   assign halted        = w_out.halted;
   assign instr_retired = w_out.retire;
   assign retired_count = rst ? {CNT_W{1'b0}} : r_count;

   // State sequencing, opcode capture in DECODE and retire counting
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FETCH;
         r_op_q  <= 4'b0000;
         r_count <= {CNT_W{1'b0}};
      end else begin
         if (w_ctrl.retire) begin
            r_count <= r_count + CNT_ONE;
         end
         case (r_state)
            ST_FETCH:     if (mem_ready) r_state <= ST_DECODE;
            ST_DECODE: begin
               r_op_q  <= op;
               r_state <= decode_next(op);
            end
            ST_EXEC_R:    r_state <= ST_ALU_WB;
            ST_EXEC_I:    r_state <= ST_ALU_WB;
            ST_ALU_WB:    r_state <= ST_FETCH;
            ST_MEM_ADDR:  r_state <= (r_op_q == OP_LHW) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  if (mem_ready) r_state <= ST_MEM_WB;
            ST_MEM_WB:    r_state <= ST_FETCH;
            ST_MEM_WRITE: if (mem_ready) r_state <= ST_FETCH;
            ST_BRANCH:    r_state <= ST_FETCH;
            ST_JUMP:      r_state <= ST_FETCH;
            ST_HALT:      r_state <= ST_HALT;
            default:      r_state <= ST_HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: the stimulus process drives one cycle at a time and
// queues the hand-written expected control word and counters; a monitor
// pops one entry per cycle at the falling edge and compares.
module tb_multicycle_control_fsm;

   // Bit positions inside the packed expected/actual control vector
   localparam int B_MREQ = 21, B_IORD = 20, B_MRD = 19, B_MWR = 18, B_IRW = 17;
   localparam int B_M2R = 16, B_RDST = 15, B_RW = 14, B_SX = 13, B_ASA = 12;
   localparam int B_PCW = 5, B_PCWC = 4, B_HLT = 1, B_RET = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] op = 4'b0000;
   logic mem_ready = 1'b0;

   logic mem_req, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite;
   logic SignExt, ALUSrcA, PCWrite, PCWriteCond, halted, instr_retired;
   logic [1:0] ALUSrcB, PCSource;
   logic [3:0] ALUOp;
   logic [15:0] retired_count;

   logic u2_mem_req, u2_IorD, u2_MemRead, u2_MemWrite, u2_IRWrite, u2_MemToReg;
   logic u2_RegDst, u2_RegWrite, u2_SignExt, u2_ALUSrcA, u2_PCWrite, u2_PCWriteCond;
   logic u2_halted, u2_instr_retired;
   logic [1:0] u2_ALUSrcB, u2_PCSource;
   logic [3:0] u2_ALUOp;
   logic [1:0] u2_retired_count;

   multicycle_control_fsm #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
      .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .SignExt(SignExt), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
      .halted(halted), .instr_retired(instr_retired), .retired_count(retired_count)
   );

   multicycle_control_fsm #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
      .mem_req(u2_mem_req), .IorD(u2_IorD), .MemRead(u2_MemRead), .MemWrite(u2_MemWrite),
      .IRWrite(u2_IRWrite), .MemToReg(u2_MemToReg), .RegDst(u2_RegDst), .RegWrite(u2_RegWrite),
      .SignExt(u2_SignExt), .ALUSrcA(u2_ALUSrcA), .ALUSrcB(u2_ALUSrcB), .ALUOp(u2_ALUOp),
      .PCWrite(u2_PCWrite), .PCWriteCond(u2_PCWriteCond), .PCSource(u2_PCSource),
      .halted(u2_halted), .instr_retired(u2_instr_retired), .retired_count(u2_retired_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [21:0] ctl;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
      string       nm;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_cnt = 16'd0;

   wire [21:0] act = {mem_req, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
                      RegWrite, SignExt, ALUSrcA, ALUSrcB, ALUOp, PCWrite,
                      PCWriteCond, PCSource, halted, instr_retired};
   wire [21:0] act2 = {u2_mem_req, u2_IorD, u2_MemRead, u2_MemWrite, u2_IRWrite,
                       u2_MemToReg, u2_RegDst, u2_RegWrite, u2_SignExt, u2_ALUSrcA,
                       u2_ALUSrcB, u2_ALUOp, u2_PCWrite, u2_PCWriteCond, u2_PCSource,
                       u2_halted, u2_instr_retired};

   // Expected control words, one per state, written straight from the state table
   function automatic logic [21:0] e_zero();
      return 22'd0;
   endfunction
   function automatic logic [21:0] e_fetch(input logic r);
      logic [21:0] v = 22'd0;
      v[B_MREQ] = 1'b1; v[B_MRD] = 1'b1; v[11:10] = 2'b01; v[9:6] = 4'b0001;
      v[B_IRW] = r; v[B_PCW] = r;
      return v;
   endfunction
   function automatic logic [21:0] e_decode();
      logic [21:0] v = 22'd0;
      v[B_SX] = 1'b1; v[11:10] = 2'b11; v[9:6] = 4'b0001;
      return v;
   endfunction
   function automatic logic [21:0] e_exec_r();
      logic [21:0] v = 22'd0;
      v[B_ASA] = 1'b1;
      return v;
   endfunction
   function automatic logic [21:0] e_exec_i(input logic [3:0] o, input logic sx);
      logic [21:0] v = 22'd0;
      v[B_ASA] = 1'b1; v[11:10] = 2'b10; v[9:6] = o; v[B_SX] = sx;
      return v;
   endfunction
   function automatic logic [21:0] e_alu_wb(input logic rdst);
      logic [21:0] v = 22'd0;
      v[B_RW] = 1'b1; v[B_RDST] = rdst; v[B_RET] = 1'b1;
      return v;
   endfunction
   function automatic logic [21:0] e_mem_addr(input logic [3:0] o);
      logic [21:0] v = 22'd0;
      v[B_ASA] = 1'b1; v[11:10] = 2'b10; v[B_SX] = 1'b1; v[9:6] = o;
      return v;
   endfunction
   function automatic logic [21:0] e_mem_read();
      logic [21:0] v = 22'd0;
      v[B_MREQ] = 1'b1; v[B_MRD] = 1'b1; v[B_IORD] = 1'b1;
      return v;
   endfunction
   function automatic logic [21:0] e_mem_wb();
      logic [21:0] v = 22'd0;
      v[B_RW] = 1'b1; v[B_M2R] = 1'b1; v[B_RET] = 1'b1;
      return v;
   endfunction
   function automatic logic [21:0] e_mem_write(input logic r);
      logic [21:0] v = 22'd0;
      v[B_MREQ] = 1'b1; v[B_MWR] = 1'b1; v[B_IORD] = 1'b1; v[B_RET] = r;
      return v;
   endfunction
   function automatic logic [21:0] e_branch(input logic [3:0] o);
      logic [21:0] v = 22'd0;
      v[B_ASA] = 1'b1; v[9:6] = o; v[B_PCWC] = 1'b1; v[3:2] = 2'b01; v[B_RET] = 1'b1;
      return v;
   endfunction
   function automatic logic [21:0] e_jump();
      logic [21:0] v = 22'd0;
      v[B_PCW] = 1'b1; v[3:2] = 2'b10; v[B_RET] = 1'b1;
      return v;
   endfunction
   function automatic logic [21:0] e_halt();
      logic [21:0] v = 22'd0;
      v[B_HLT] = 1'b1;
      return v;
   endfunction

   // Drive one cycle of inputs and queue what the outputs must be in that cycle
   task automatic step(input logic r, input logic [3:0] o, input logic mr,
                       input logic [21:0] e, input string nm);
      exp_t x;
      @(posedge clk);
      #1;
      rst = r;
      op = o;
      mem_ready = mr;
      if (r) exp_cnt = 16'd0;
      x.ctl = e;
      x.cnt = exp_cnt;
      x.cnt2 = exp_cnt[1:0];
      x.nm = nm;
      q.push_back(x);
      if (!r && e[B_RET]) exp_cnt = exp_cnt + 16'd1;
   endtask

   // Monitor: one queued expectation per cycle, checked mid-cycle
   always @(negedge clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         total++;
         if (act !== mon_e.ctl) begin
            bad++;
            $display("FAIL %s ctl got=%b want=%b", mon_e.nm, act, mon_e.ctl);
         end
         total++;
         if (act2 !== mon_e.ctl) begin
            bad++;
            $display("FAIL %s ctl_w2 got=%b want=%b", mon_e.nm, act2, mon_e.ctl);
         end
         total++;
         if (retired_count !== mon_e.cnt) begin
            bad++;
            $display("FAIL %s count got=%0d want=%0d", mon_e.nm, retired_count, mon_e.cnt);
         end
         total++;
         if (u2_retired_count !== mon_e.cnt2) begin
            bad++;
            $display("FAIL %s count_w2 got=%0d want=%0d", mon_e.nm, u2_retired_count, mon_e.cnt2);
         end
      end
   end

   initial begin
      // reset: everything low
      step(1'b1, 4'h0, 1'b1, e_zero(), "rst0");
      step(1'b1, 4'h0, 1'b1, e_zero(), "rst1");
      // addi, zero-wait: 4 cycles, sign-extended, writes rt
      step(1'b0, 4'h1, 1'b1, e_fetch(1'b1), "addi_fetch");
      step(1'b0, 4'h1, 1'b1, e_decode(), "addi_dec");
      step(1'b0, 4'h1, 1'b1, e_exec_i(4'b0001, 1'b1), "addi_exec");
      step(1'b0, 4'h1, 1'b1, e_alu_wb(1'b0), "addi_wb");
      // lhw with two memory wait cycles: 7 cycles
      step(1'b0, 4'h7, 1'b1, e_fetch(1'b1), "lhw_fetch");
      step(1'b0, 4'h7, 1'b1, e_decode(), "lhw_dec");
      step(1'b0, 4'h7, 1'b1, e_mem_addr(4'b0111), "lhw_addr");
      step(1'b0, 4'h7, 1'b0, e_mem_read(), "lhw_rd_w0");
      step(1'b0, 4'h7, 1'b0, e_mem_read(), "lhw_rd_w1");
      step(1'b0, 4'h7, 1'b1, e_mem_read(), "lhw_rd");
      step(1'b0, 4'h7, 1'b1, e_mem_wb(), "lhw_wb");
      // beq then jmp: 3 cycles each
      step(1'b0, 4'h9, 1'b1, e_fetch(1'b1), "beq_fetch");
      step(1'b0, 4'h9, 1'b1, e_decode(), "beq_dec");
      step(1'b0, 4'h9, 1'b1, e_branch(4'b1001), "beq_br");
      step(1'b0, 4'hF, 1'b1, e_fetch(1'b1), "jmp_fetch");
      step(1'b0, 4'hF, 1'b1, e_decode(), "jmp_dec");
      step(1'b0, 4'hF, 1'b1, e_jump(), "jmp_j");
      // andi with one fetch wait: zero-extended immediate
      step(1'b0, 4'h2, 1'b0, e_fetch(1'b0), "andi_fwait");
      step(1'b0, 4'h2, 1'b1, e_fetch(1'b1), "andi_fetch");
      step(1'b0, 4'h2, 1'b1, e_decode(), "andi_dec");
      step(1'b0, 4'h2, 1'b1, e_exec_i(4'b0010, 1'b0), "andi_exec");
      step(1'b0, 4'h2, 1'b1, e_alu_wb(1'b0), "andi_wb");
      // shw with one write wait: retires only on the ready cycle
      step(1'b0, 4'h8, 1'b1, e_fetch(1'b1), "shw_fetch");
      step(1'b0, 4'h8, 1'b1, e_decode(), "shw_dec");
      step(1'b0, 4'h8, 1'b1, e_mem_addr(4'b1000), "shw_addr");
      step(1'b0, 4'h8, 1'b0, e_mem_write(1'b0), "shw_wr_w0");
      step(1'b0, 4'h8, 1'b1, e_mem_write(1'b1), "shw_wr");
      // bgt
      step(1'b0, 4'hC, 1'b1, e_fetch(1'b1), "bgt_fetch");
      step(1'b0, 4'hC, 1'b1, e_decode(), "bgt_dec");
      step(1'b0, 4'hC, 1'b1, e_branch(4'b1100), "bgt_br");
      // illegal opcode 0101: HALT, ignores mem_ready and op, count frozen
      step(1'b0, 4'h5, 1'b1, e_fetch(1'b1), "ill_fetch");
      step(1'b0, 4'h5, 1'b1, e_decode(), "ill_dec");
      step(1'b0, 4'h1, 1'b0, e_halt(), "halt0");
      step(1'b0, 4'h0, 1'b1, e_halt(), "halt1");
      step(1'b0, 4'h7, 1'b0, e_halt(), "halt2");
      step(1'b1, 4'h0, 1'b1, e_zero(), "halt_rst");
      // reset during a fetch wait: outputs drop at once, then a clean FETCH
      step(1'b0, 4'h0, 1'b0, e_fetch(1'b0), "post_halt_fetch");
      step(1'b1, 4'h0, 1'b0, e_zero(), "fwait_rst");
      step(1'b0, 4'h0, 1'b0, e_fetch(1'b0), "after_rst_fetch");
      // four back-to-back R-types: 2-bit counter goes 1,2,3,0
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 4'h0, 1'b1, e_fetch(1'b1), "r_fetch");
         step(1'b0, 4'h0, 1'b1, e_decode(), "r_dec");
         step(1'b0, 4'h0, 1'b1, e_exec_r(), "r_exec");
         step(1'b0, 4'h0, 1'b1, e_alu_wb(1'b1), "r_wb");
      end
      // reset in the middle of a data read
      step(1'b0, 4'h7, 1'b1, e_fetch(1'b1), "lhw2_fetch");
      step(1'b0, 4'h7, 1'b1, e_decode(), "lhw2_dec");
      step(1'b0, 4'h7, 1'b1, e_mem_addr(4'b0111), "lhw2_addr");
      step(1'b0, 4'h7, 1'b0, e_mem_read(), "lhw2_rd_w0");
      step(1'b1, 4'h7, 1'b0, e_zero(), "rd_rst");
      step(1'b0, 4'h0, 1'b1, e_fetch(1'b1), "final_fetch");
      step(1'b0, 4'h0, 1'b1, e_decode(), "final_dec");
      @(posedge clk);
      @(posedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
